// File: rtl/clockctrl_axil_slave.sv
// clockctrl AXI4-Lite slave: CTRL/DIV/SCRATCH0/SCRATCH1 at 0x0..0xC
// driving a programmable tick divider. Ports: ACLK, ARESET (sync,
// active-high), S_AXI_* AXI4-Lite slave, tick, clk_en_out.
// Optional macro CLKCTRL_TICK_CNT_EN adds a read-only tick counter
// at 0x10 (cleared by any write to 0x10).
module clockctrl_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_RESET_DIV        = 32'h0
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            tick,
  output logic                            clk_en_out
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic [DW-1:0] ctrl_q;
  logic [DW-1:0] div_q;
  logic [DW-1:0] scr0_q;
  logic [DW-1:0] scr1_q;
  logic [DW-1:0] count_q;
  logic [DW-1:0] rd_data;
  logic [2:0]    wr_idx;
  logic [2:0]    rd_idx;
  logic          aw_hs;
  logic          ar_hs;
  logic          div_wr;
  logic          unused_ok;

  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready is a one-cycle pulse; the handshake completes in that cycle.
  assign aw_hs = S_AXI_AWREADY & S_AXI_AWVALID
               & S_AXI_WREADY & S_AXI_WVALID;
  assign ar_hs = S_AXI_ARREADY & S_AXI_ARVALID;

  assign div_wr = aw_hs & (wr_idx == 3'd1);

  // A DIV write restarts the count, so suppress the terminal tick.
  assign tick = ctrl_q[0] & ~div_wr & (count_q == div_q);

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] data,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < SW; k++)
      if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
    return r;
  endfunction

`ifdef CLKCTRL_TICK_CNT_EN
  logic [DW-1:0] tick_cnt_q;

  always_ff @(posedge ACLK) begin
    if (ARESET)
      tick_cnt_q <= '0;
    else if (aw_hs && wr_idx == 3'd4)
      tick_cnt_q <= '0;
    else if (tick)
      tick_cnt_q <= tick_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      3'd0:    rd_data = ctrl_q;
      3'd1:    rd_data = div_q;
      3'd2:    rd_data = scr0_q;
      3'd3:    rd_data = scr1_q;
`ifdef CLKCTRL_TICK_CNT_EN
      3'd4:    rd_data = tick_cnt_q;
`endif
      default: rd_data = '0;
    endcase
  end

  // Write channel and register file
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      ctrl_q        <= '0;
      div_q         <= C_RESET_DIV;
      scr0_q        <= '0;
      scr1_q        <= '0;
    end else begin
      S_AXI_AWREADY <= ~S_AXI_AWREADY & S_AXI_AWVALID
                     & S_AXI_WVALID & ~S_AXI_BVALID;
      S_AXI_WREADY  <= ~S_AXI_AWREADY & S_AXI_AWVALID
                     & S_AXI_WVALID & ~S_AXI_BVALID;
      S_AXI_BRESP   <= 2'b00;
      if (aw_hs)
        S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY)
        S_AXI_BVALID <= 1'b0;
      if (aw_hs) begin
        case (wr_idx)
          3'd0: ctrl_q <= merge(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
          3'd1: div_q  <= merge(div_q,  S_AXI_WDATA, S_AXI_WSTRB);
          3'd2: scr0_q <= merge(scr0_q, S_AXI_WDATA, S_AXI_WSTRB);
          3'd3: scr1_q <= merge(scr1_q, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
    end
  end

  // Read channel; RDATA is captured at the handshake and held.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
    end else begin
      S_AXI_ARREADY <= ~S_AXI_ARREADY & S_AXI_ARVALID
                     & ~S_AXI_RVALID;
      S_AXI_RRESP   <= 2'b00;
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Divider
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      count_q    <= '0;
      clk_en_out <= 1'b0;
    end else if (!ctrl_q[0]) begin
      count_q    <= '0;
      clk_en_out <= 1'b0;
    end else begin
      if (div_wr || tick)
        count_q <= '0;
      else
        count_q <= count_q + 1'b1;
      if (tick)
        clk_en_out <= ~clk_en_out;
    end
  end

endmodule

// File: tb/tb_clockctrl_axil_slave.sv
// Self-checking bench for clockctrl_axil_slave: randomized register
// traffic against a byte-lane model plus divider timing checks.
module tb_clockctrl_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        tick;
  logic        clk_en_out;

  int checks = 0;
  int passed = 0;
  logic [31:0] mdl [4];

  always #5 ACLK = ~ACLK;

  clockctrl_axil_slave dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .tick          (tick),
    .clk_en_out    (clk_en_out)
  );

  function automatic logic [31:0] lanes(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] expect_rd(input int idx);
    return (idx < 4) ? mdl[idx] : 32'h0;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d,
                             input logic [3:0] s);
    if (idx < 4) mdl[idx] = lanes(mdl[idx], d, s);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r,
                           output bit ok);
    ok = 0;
    r = 2'b11;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge ACLK);
      #1;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    if (!ok) return;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin r = S_AXI_BRESP; ok = 1; break; end
    end
    @(posedge ACLK);
    #1 S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] r, output bit ok);
    ok = 0;
    d = 32'h0;
    r = 2'b11;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge ACLK);
      #1;
    end
    S_AXI_ARVALID = 1'b0;
    if (!ok) return;
    S_AXI_RREADY = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin
        d = S_AXI_RDATA; r = S_AXI_RRESP; ok = 1; break;
      end
    end
    @(posedge ACLK);
    #1 S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    @(negedge ACLK);
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
         S_AXI_RVALID, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP,
         tick, clk_en_out} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs rdata=%h",
               S_AXI_RDATA);
    else passed++;
    #1 ARESET = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h0 || r !== 2'b00)
        $display("FAIL reset_reg%0d: got %h resp %b ok %0d want 0",
                 i, d, r, ok);
      else passed++;
    end
  endtask

  task automatic test_basic_rw();
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    int          toggles;
    logic        prev;
    for (int i = 3; i >= 0; i--) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, r, ok);
      model_write(i, 32'(i + 1), 4'hF);
      checks++;
      if (!ok || r !== 2'b00)
        $display("FAIL basic_bresp%0d: got %b ok %0d want 00", i, r, ok);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r, ok);
      checks++;
      if (!ok || d !== expect_rd(i) || r !== 2'b00)
        $display("FAIL basic_read%0d: got %h resp %b want %h",
                 i, d, r, expect_rd(i));
      else passed++;
    end
    toggles = 0;
    prev = clk_en_out;
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      if (clk_en_out !== prev) toggles++;
      prev = clk_en_out;
    end
    checks++;
    if (toggles != 4)
      $display("FAIL basic_clk_en: got %0d toggles want 4", toggles);
    else passed++;
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    axi_write(5'h08, 32'hAABBCCDD, 4'hF, r, ok);
    axi_write(5'h08, 32'h11223344, 4'b0101, r, ok);
    model_write(2, 32'hAABBCCDD, 4'hF);
    model_write(2, 32'h11223344, 4'b0101);
    axi_read(5'h08, d, r, ok);
    checks++;
    if (!ok || d !== 32'hAA22CC44)
      $display("FAIL strobe: got %h want aa22cc44", d);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] d, wd;
    logic [1:0]  r;
    logic [3:0]  s;
    bit          ok;
    int          wi, ri;
    for (int n = 0; n < 30; n++) begin
      wi = int'($urandom_range(0, 6));
      if (wi >= 4) wi++;
      wd = $urandom;
      s = 4'($urandom);
      axi_write(5'(wi * 4) | 5'($urandom_range(0, 3)), wd, s, r, ok);
      model_write(wi, wd, s);
      checks++;
      if (!ok || r !== 2'b00)
        $display("FAIL rand_bresp%0d: got %b ok %0d", n, r, ok);
      else passed++;
      ri = int'($urandom_range(0, 6));
      if (ri >= 4) ri++;
      axi_read(5'(ri * 4), d, r, ok);
      checks++;
      if (!ok || d !== expect_rd(ri) || r !== 2'b00)
        $display("FAIL rand_read%0d idx %0d: got %h resp %b want %h",
                 n, ri, d, r, expect_rd(ri));
      else passed++;
    end
  endtask

  task automatic test_divider();
    logic [1:0] r;
    bit         ok;
    int         dv, last, nt, bad_ce, bad_iv;
    logic       pt, pc;
    int         divs [4];
    do_reset();
    divs[0] = 3;
    divs[1] = 0;
    divs[2] = int'($urandom_range(1, 6));
    divs[3] = int'($urandom_range(1, 6));
    axi_write(5'h04, 32'(divs[0]), 4'hF, r, ok);
    axi_write(5'h00, 32'h1, 4'hF, r, ok);
    for (int k = 0; k < 4; k++) begin
      dv = divs[k];
      if (k > 0) axi_write(5'h04, 32'(dv), 4'hF, r, ok);
      last = -1; nt = 0; bad_ce = 0; bad_iv = 0;
      @(negedge ACLK);
      pt = tick; pc = clk_en_out;
      if (tick) begin last = 0; nt = 1; end
      for (int i = 1; i < 8 * (dv + 1) + 2; i++) begin
        @(negedge ACLK);
        if (clk_en_out !== (pc ^ pt)) bad_ce++;
        if (tick) begin
          if (last >= 0 && i - last != dv + 1) bad_iv++;
          last = i; nt++;
        end
        pt = tick; pc = clk_en_out;
      end
      checks++;
      if (bad_iv != 0 || nt < 7)
        $display("FAIL div%0d_interval: %0d bad, %0d ticks, want period %0d",
                 dv, bad_iv, nt, dv + 1);
      else passed++;
      checks++;
      if (bad_ce != 0)
        $display("FAIL div%0d_clk_en: %0d bad toggles want 0", dv, bad_ce);
      else passed++;
    end
    axi_write(5'h00, 32'h0, 4'hF, r, ok);
    @(negedge ACLK);
    checks++;
    if (tick !== 1'b0 || clk_en_out !== 1'b0)
      $display("FAIL div_disable: tick %b clk_en %b want 0 0",
               tick, clk_en_out);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    int          bad_b, bad_aw;
    do_reset();
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin ok = 1; break; end
    end
    @(posedge ACLK);
    #1 S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h9ABCDEF0;
    model_write(2, 32'h12345678, 4'hF);
    bad_b = 0; bad_aw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID !== 1'b1) bad_b++;
      if (S_AXI_AWREADY !== 1'b0) bad_aw++;
    end
    checks++;
    if (!ok || bad_b != 0)
      $display("FAIL bp_bvalid_hold: %0d cycles low ok %0d want 0", bad_b, ok);
    else passed++;
    checks++;
    if (bad_aw != 0)
      $display("FAIL bp_awready_block: %0d cycles high want 0", bad_aw);
    else passed++;
    S_AXI_BREADY = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin ok = 1; break; end
    end
    @(posedge ACLK);
    #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    model_write(3, 32'h9ABCDEF0, 4'hF);
    repeat (2) @(posedge ACLK);
    #1 S_AXI_BREADY = 1'b0;
    checks++;
    if (!ok) $display("FAIL bp_second_accept: ok %0d want 1", ok);
    else passed++;
    for (int i = 2; i < 4; i++) begin
      axi_read(5'(i * 4), d, r, ok);
      checks++;
      if (!ok || d !== expect_rd(i))
        $display("FAIL bp_read%0d: got %h want %h", i, d, expect_rd(i));
      else passed++;
    end
  endtask

  task automatic test_aw_before_w();
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    int          early;
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b1;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY || S_AXI_WREADY || S_AXI_BVALID) early++;
    end
    checks++;
    if (early != 0)
      $display("FAIL aw_only_wait: %0d early accepts want 0", early);
    else passed++;
    S_AXI_WVALID = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin ok = 1; break; end
    end
    @(posedge ACLK);
    #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    model_write(3, 32'hCAFEF00D, 4'hF);
    repeat (2) @(posedge ACLK);
    #1 S_AXI_BREADY = 1'b0;
    axi_read(5'h0C, d, r, ok);
    checks++;
    if (!ok || d !== expect_rd(3))
      $display("FAIL aw_w_read: got %h want %h", d, expect_rd(3));
    else passed++;
    axi_read(5'h14, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00)
      $display("FAIL unmapped_read: got %h resp %b want 0 00", d, r);
    else passed++;
  endtask

  task automatic test_same_cycle_rw();
    logic [31:0] old, d;
    logic [1:0]  r;
    bit          ok;
    old = expect_rd(2);
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h08; S_AXI_WDATA = ~old; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY && S_AXI_ARREADY) begin ok = 1; break; end
    end
    @(posedge ACLK);
    #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model_write(2, ~old, 4'hF);
    @(negedge ACLK);
    checks++;
    if (!ok || S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== old)
      $display("FAIL same_cycle_old: got %h rvalid %b want %h",
               S_AXI_RDATA, S_AXI_RVALID, old);
    else passed++;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    #1 S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    axi_read(5'h08, d, r, ok);
    checks++;
    if (!ok || d !== expect_rd(2))
      $display("FAIL same_cycle_new: got %h want %h", d, expect_rd(2));
    else passed++;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    axi_write(5'h04, 32'h1, 4'hF, r, ok);
    axi_write(5'h00, 32'h1, 4'hF, r, ok);
    axi_write(5'h08, 32'h55AA55AA, 4'hF, r, ok);
    @(negedge ACLK);
    S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin ok = 1; break; end
      if (S_AXI_ARREADY) begin
        @(posedge ACLK);
        #1 S_AXI_ARVALID = 1'b0;
      end
    end
    S_AXI_ARVALID = 1'b0;
    ARESET = 1'b1;
    @(negedge ACLK);
    checks++;
    if (!ok || S_AXI_RVALID !== 1'b0 || tick !== 1'b0
        || clk_en_out !== 1'b0 || S_AXI_RDATA !== 32'h0)
      $display("FAIL reset_mid_read: ok %0d rvalid %b tick %b clk_en %b",
               ok, S_AXI_RVALID, tick, clk_en_out);
    else passed++;
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h0)
        $display("FAIL reset_mid_reg%0d: got %h want 0", i, d);
      else passed++;
    end
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    repeat (3) @(posedge ACLK);
    test_reset();
    test_basic_rw();
    test_strobe();
    test_random();
    test_divider();
    test_backpressure();
    test_aw_before_w();
    test_same_cycle_rw();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
